// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 decode, FSM states,
// alignment check and load-lane extension.
package lsu_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } mem_f3_e;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StResp
  } lsu_state_e;

  // Unsigned sizes only exist for loads.
  function automatic logic is_illegal(input logic [2:0] f3, input logic we);
    logic bad;
    case (f3)
      F3_B, F3_H, F3_W: bad = 1'b0;
      F3_BU, F3_HU:     bad = we;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr);
    logic mis;
    case (f3)
      F3_H, F3_HU: mis = addr[0];
      F3_W:        mis = (addr != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [1:0]  lane_sel,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{lane_sel, 3'b000} +: 8];
    h = lane_sel[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    res = {{24{b[7]}}, b};
      F3_H:    res = {{16{h[15]}}, h};
      F3_BU:   res = {24'h0, b};
      F3_HU:   res = {16'h0, h};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/data_mem_lsu_if.sv
// Request/response bundle between a requester (master) and the LSU (slave).
interface data_mem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] dataR;
  logic        fault;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, dataR, fault
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, dataR, fault
  );
endinterface

// File: rtl/dmem_ram.sv
// Single-port word RAM with byte-enable writes and a registered read; no reset.
module dmem_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    // Read register only moves on a read so the word stays stable until used.
    if (re_i) rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit: one request at a time, byte-enabled stores, extended loads,
// fault reporting for misaligned or illegal accesses.
module data_mem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input logic           clk,
  input logic           rst_n,
  data_mem_lsu_if.slave bus
);

  lsu_state_e  state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;
  logic        fault_q, fault_d;
  logic [31:0] data_r_q, data_r_d;

  logic        accept;
  logic        req_fault;
  logic        ram_we;
  logic        ram_re;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        unused_addr;

  assign unused_addr = ^bus.req_addr[31:AW+2];

  // Reset low at an edge blocks the accept, and with it any RAM write.
  assign accept    = bus.req_valid && (state_q == StIdle) && rst_n;
  assign req_fault = is_illegal(bus.req_funct3, bus.req_we) ||
                     is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
  assign ram_we    = accept && bus.req_we && !req_fault;
  assign ram_re    = accept && !bus.req_we && !req_fault;

  always_comb begin
    ram_be    = 4'hF;
    ram_wdata = bus.req_wdata;
    case (bus.req_funct3)
      F3_B: begin
        ram_be    = 4'b0001 << bus.req_addr[1:0];
        ram_wdata = {4{bus.req_wdata[7:0]}};
      end
      F3_H: begin
        ram_be    = 4'b0011 << bus.req_addr[1:0];
        ram_wdata = {2{bus.req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (bus.req_addr[AW+1:2]),
    .be_i    (ram_be),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    lane_d   = lane_q;
    fault_d  = fault_q;
    data_r_d = data_r_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = ram_re ? StRd : StResp;
          f3_d    = bus.req_funct3;
          lane_d  = bus.req_addr[1:0];
          fault_d = req_fault;
        end
      end
      StRd: begin
        state_d  = StResp;
        data_r_d = load_extend(f3_q, lane_q, ram_rdata);
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      f3_q     <= 3'b000;
      lane_q   <= 2'b00;
      fault_q  <= 1'b0;
      data_r_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      lane_q   <= lane_d;
      fault_q  <= fault_d;
      data_r_q <= data_r_d;
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.fault     = (state_q == StResp) && fault_q;
  assign bus.dataR     = data_r_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed self-checking bench for data_mem_lsu.
module tb_data_mem_lsu;
  import lsu_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_lsu_if bus ();

  data_mem_lsu #(
    .DEPTH_WORDS (1024)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          total = 0;
  int          bad   = 0;
  int          lat;
  logic        flt;
  logic [31:0] dat;

  // Drives one request, waits for accept, then records response latency/fault/data.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    int w;
    @(posedge clk); #1;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    w = 0;
    @(negedge clk);
    while (!bus.req_ready && w < 8) begin
      w++;
      @(negedge clk);
    end
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_timeout addr=%h ready=%b want 1", addr, bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    flt = 1'bx;
    dat = 32'hx;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        lat = i;
        flt = bus.fault;
        dat = bus.dataR;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp got=%b want 0", bus.rsp_valid); end
    total++; if (bus.fault !== 1'b0) begin bad++; $display("FAIL rst_fault got=%b want 0", bus.fault); end
    total++; if (bus.dataR !== 32'h0) begin bad++; $display("FAIL rst_data got=%h want 0", bus.dataR); end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want 1", bus.req_ready); end
  endtask

  task automatic test_word();
    issue(1'b1, F3_W, 32'h10, 32'hDEADBEEF);
    total++; if (lat !== 1) begin bad++; $display("FAIL sw_lat got=%0d want 1", lat); end
    total++; if (flt !== 1'b0) begin bad++; $display("FAIL sw_fault got=%b want 0", flt); end
    issue(1'b0, F3_W, 32'h10, 32'h0);
    total++; if (lat !== 2) begin bad++; $display("FAIL lw_lat got=%0d want 2", lat); end
    total++; if (flt !== 1'b0) begin bad++; $display("FAIL lw_fault got=%b want 0", flt); end
    total++; if (dat !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data got=%h want deadbeef", dat); end
  endtask

  task automatic test_byte();
    issue(1'b1, F3_B, 32'h13, 32'h00000080);
    total++; if (lat !== 1) begin bad++; $display("FAIL sb_lat got=%0d want 1", lat); end
    issue(1'b0, F3_B, 32'h13, 32'h0);
    total++; if (dat !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_data got=%h want ffffff80", dat); end
    issue(1'b0, F3_BU, 32'h13, 32'h0);
    total++; if (dat !== 32'h00000080) begin bad++; $display("FAIL lbu_data got=%h want 00000080", dat); end
    issue(1'b0, F3_W, 32'h10, 32'h0);
    total++; if (dat !== 32'h80ADBEEF) begin bad++; $display("FAIL sb_word got=%h want 80adbeef", dat); end
  endtask

  task automatic test_half();
    issue(1'b1, F3_H, 32'h12, 32'h00001234);
    total++; if (flt !== 1'b0) begin bad++; $display("FAIL sh_fault got=%b want 0", flt); end
    issue(1'b0, F3_H, 32'h12, 32'h0);
    total++; if (dat !== 32'h00001234) begin bad++; $display("FAIL lh_data got=%h want 00001234", dat); end
    issue(1'b0, F3_HU, 32'h10, 32'h0);
    total++; if (dat !== 32'h0000BEEF) begin bad++; $display("FAIL lhu_data got=%h want 0000beef", dat); end
    issue(1'b0, F3_W, 32'h10, 32'h0);
    total++; if (dat !== 32'h1234BEEF) begin bad++; $display("FAIL sh_word got=%h want 1234beef", dat); end
  endtask

  task automatic test_fault();
    issue(1'b0, F3_W, 32'h11, 32'h0);
    total++; if (lat !== 1) begin bad++; $display("FAIL lw_mis_lat got=%0d want 1", lat); end
    total++; if (flt !== 1'b1) begin bad++; $display("FAIL lw_mis_fault got=%b want 1", flt); end
    total++; if (dat !== 32'h1234BEEF) begin bad++; $display("FAIL lw_mis_data got=%h want 1234beef", dat); end
    issue(1'b1, F3_H, 32'h13, 32'h0000FFFF);
    total++; if (flt !== 1'b1 || lat !== 1) begin
      bad++; $display("FAIL sh_mis got fault=%b lat=%0d want 1/1", flt, lat);
    end
    issue(1'b0, 3'b011, 32'h10, 32'h0);
    total++; if (flt !== 1'b1 || lat !== 1) begin
      bad++; $display("FAIL f3_011 got fault=%b lat=%0d want 1/1", flt, lat);
    end
    issue(1'b1, F3_BU, 32'h10, 32'h000000AA);
    total++; if (flt !== 1'b1) begin bad++; $display("FAIL store_bu got=%b want 1", flt); end
    issue(1'b0, F3_W, 32'h10, 32'h0);
    total++; if (dat !== 32'h1234BEEF || flt !== 1'b0) begin
      bad++; $display("FAIL fault_nowrite got=%h/%b want 1234beef/0", dat, flt);
    end
  endtask

  task automatic test_back_to_back();
    int   nrdy;
    int   nrsp;
    logic rdy;
    nrdy = 0;
    nrsp = 0;
    @(posedge clk); #1;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 32'h1010;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      rdy = bus.req_ready;
      if (c < 9) begin
        total++;
        if (rdy !== 1'((c % 3) == 0)) begin
          bad++; $display("FAIL b2b_ready c=%0d got=%b want %b", c, rdy, (c % 3) == 0);
        end
      end
      if (rdy && bus.req_valid) nrdy++;
      if (bus.rsp_valid === 1'b1) begin
        nrsp++;
        total++;
        if (bus.dataR !== 32'h1234BEEF) begin
          bad++; $display("FAIL b2b_wrap_data got=%h want 1234beef", bus.dataR);
        end
      end
      @(posedge clk); #1;
      if (nrdy == 3) bus.req_valid = 1'b0;
    end
    total++; if (nrsp !== 3) begin bad++; $display("FAIL b2b_rsp_count got=%0d want 3", nrsp); end
  endtask

  task automatic test_reset_mid();
    int nrsp;
    issue(1'b1, F3_W, 32'h20, 32'hCAFEF00D);
    total++; if (lat !== 1) begin bad++; $display("FAIL sw20_lat got=%0d want 1", lat); end
    @(posedge clk); #1;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 32'h20;
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b want 1", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst_n         = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    nrsp  = 0;
    @(negedge clk);
    total++; if (bus.dataR !== 32'h0) begin bad++; $display("FAIL mid_data got=%h want 0", bus.dataR); end
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL mid_ready_after got=%b want 1", bus.req_ready); end
    for (int i = 0; i < 4; i++) begin
      if (bus.rsp_valid === 1'b1) nrsp++;
      @(negedge clk);
    end
    total++; if (nrsp !== 0) begin bad++; $display("FAIL mid_rsp got=%0d want 0", nrsp); end
    // A store presented while reset is low must not be written.
    @(posedge clk); #1;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'h11111111;
    @(posedge clk); #1;
    rst_n         = 1'b1;
    bus.req_valid = 1'b0;
    issue(1'b0, F3_W, 32'h20, 32'h0);
    total++; if (dat !== 32'hCAFEF00D || lat !== 2) begin
      bad++; $display("FAIL rst_store got=%h lat=%0d want cafef00d/2", dat, lat);
    end
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_fault();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule
